// File: rtl/riscv_mtimer.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime with prescaled tick,
// mtimecmp compare driving a registered level interrupt, single-cycle slave port.
module riscv_mtimer #(
  parameter int DW      = 32,
  parameter int ADDRW   = 12,
  parameter int PRESC_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [ADDRW-1:0] addr_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW-1:0]    rdata_o,
  output logic             ack_o,
  output logic             t_intr
);

  typedef enum logic [2:0] {
    SEL_MTIME_LO = 3'd0,
    SEL_MTIME_HI = 3'd1,
    SEL_CMP_LO   = 3'd2,
    SEL_CMP_HI   = 3'd3,
    SEL_CTRL     = 3'd4
  } reg_sel_e;

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        hi_snap_q, hi_snap_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               ack_q, ack_d;
  logic               intr_q, intr_d;

  reg_sel_e    sel;
  logic        wr, rd, tick;
  logic [31:0] ctrl_rd;
  logic        unused_addr;

  assign unused_addr = ^{addr_i[ADDRW-1:5], addr_i[1:0]};

  always_comb begin
    sel  = reg_sel_e'(addr_i[4:2]);
    wr   = req_i & we_i;
    rd   = req_i & ~we_i;
    tick = en_q && (pcnt_q == presc_q);

    ctrl_rd                = '0;
    ctrl_rd[0]             = en_q;
    ctrl_rd[8 +: PRESC_W]  = presc_q;

    // A write to either mtime half wins over the tick: no increment that cycle.
    mtime_d = mtime_q;
    if (wr && sel == SEL_MTIME_LO)      mtime_d[31:0]  = wdata_i[31:0];
    else if (wr && sel == SEL_MTIME_HI) mtime_d[63:32] = wdata_i[31:0];
    else if (tick)                      mtime_d        = mtime_q + 64'd1;

    mtimecmp_d = mtimecmp_q;
    if (wr && sel == SEL_CMP_LO) mtimecmp_d[31:0]  = wdata_i[31:0];
    if (wr && sel == SEL_CMP_HI) mtimecmp_d[63:32] = wdata_i[31:0];

    en_d    = en_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (wr && sel == SEL_CTRL) begin
      en_d    = wdata_i[0];
      presc_d = wdata_i[8 +: PRESC_W];
      pcnt_d  = '0;
    end else if (tick) begin
      pcnt_d  = '0;
    end else if (en_q) begin
      pcnt_d  = pcnt_q + 1'b1;
    end

    hi_snap_d = hi_snap_q;
    if (rd && sel == SEL_MTIME_LO) hi_snap_d = mtime_q[63:32];

    rdata_d = '0;
    if (rd) begin
      case (sel)
        SEL_MTIME_LO: rdata_d = mtime_q[31:0];
        SEL_MTIME_HI: rdata_d = hi_snap_q;
        SEL_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        SEL_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        SEL_CTRL:     rdata_d = ctrl_rd;
        default:      rdata_d = '0;
      endcase
    end

    ack_d  = req_i;
    intr_d = en_q && (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      hi_snap_q  <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      hi_snap_q  <= hi_snap_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      intr_q     <= intr_d;
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign t_intr  = intr_q;

endmodule

// File: tb/tb_riscv_mtimer.sv
// Self-checking bench for riscv_mtimer: directed scenarios with fixed expectations
// plus a randomized bus run compared against a cycle-level reference model.
module tb_riscv_mtimer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        t_intr;

  int checks = 0;
  int failures = 0;

  riscv_mtimer #(.DW(32), .ADDRW(12), .PRESC_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .t_intr(t_intr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_mt, m_cmp;
  logic        m_en;
  logic [7:0]  m_presc, m_pcnt;
  logic [31:0] m_snap;
  logic        e_ack, e_intr;
  logic [31:0] e_rd;

  task automatic model_reset();
    m_mt = 64'd0; m_cmp = '1; m_en = 1'b0; m_presc = 8'd0; m_pcnt = 8'd0;
    m_snap = 32'd0; e_ack = 1'b0; e_rd = 32'd0; e_intr = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [2:0] off;
    bit wr, rd, tick;
    off  = addr[4:2];
    wr   = req && we;
    rd   = req && !we;
    tick = m_en && (m_pcnt == m_presc);
    e_ack  = req;
    e_intr = m_en && (m_mt >= m_cmp);
    e_rd   = 32'd0;
    if (rd) begin
      case (off)
        3'd0: e_rd = m_mt[31:0];
        3'd1: e_rd = m_snap;
        3'd2: e_rd = m_cmp[31:0];
        3'd3: e_rd = m_cmp[63:32];
        3'd4: e_rd = {16'd0, m_presc, 7'd0, m_en};
        default: e_rd = 32'd0;
      endcase
      if (off == 3'd0) m_snap = m_mt[63:32];
    end
    if (wr && off == 3'd0)      m_mt = {m_mt[63:32], wdata};
    else if (wr && off == 3'd1) m_mt = {wdata, m_mt[31:0]};
    else if (tick)              m_mt = m_mt + 64'd1;
    if (wr && off == 3'd2) m_cmp = {m_cmp[63:32], wdata};
    if (wr && off == 3'd3) m_cmp = {wdata, m_cmp[31:0]};
    if (wr && off == 3'd4) begin
      m_en = wdata[0]; m_presc = wdata[15:8]; m_pcnt = 8'd0;
    end else if (tick) begin
      m_pcnt = 8'd0;
    end else if (m_en) begin
      m_pcnt = m_pcnt + 8'd1;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input bit w, input logic [11:0] a, input logic [31:0] d,
                     output logic ak, output logic [31:0] rd);
    req = 1'b1; we = w; addr = a; wdata = d;
    model_step();
    @(posedge clk);
    #1;
    ak = ack; rd = rdata;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic apply_reset();
    req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic ak; logic [31:0] rd;
    bus(1'b1, 12'h008, 32'd3, ak, rd);
    bus(1'b1, 12'h00C, 32'd0, ak, rd);
    bus(1'b1, 12'h010, 32'h1, ak, rd);
    cyc(6);
    checks++;
    if (t_intr !== 1'b1) begin failures++; $display("FAIL pre_reset_intr: got %b expected 1", t_intr); end
    req = 1'b1; we = 1'b0; addr = 12'h008;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (t_intr !== 1'b0) begin failures++; $display("FAIL reset_intr: got %b expected 0", t_intr); end
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++;
    if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL reset_pending_ack: got %b expected 0", ack); end
    req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    bus(1'b0, 12'h008, 32'd0, ak, rd);
    checks++;
    if (ak !== 1'b1 || rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_lo: got ack=%b data=%h expected ack=1 data=ffffffff", ak, rd); end
    bus(1'b0, 12'h00C, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", rd); end
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL reset_mtime_lo: got %h expected 0", rd); end
  endtask

  task automatic test_basic_compare();
    logic ak; logic [31:0] rd;
    apply_reset();
    bus(1'b1, 12'h008, 32'd5, ak, rd);
    bus(1'b1, 12'h00C, 32'd0, ak, rd);
    bus(1'b1, 12'h010, 32'h1, ak, rd);
    cyc(5);
    checks++;
    if (t_intr !== 1'b0) begin failures++; $display("FAIL cmp_intr_early: got %b expected 0", t_intr); end
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd5) begin failures++; $display("FAIL cmp_mtime5: got %0d expected 5", rd); end
    checks++;
    if (t_intr !== 1'b1) begin failures++; $display("FAIL cmp_intr_rise: got %b expected 1", t_intr); end
    cyc(3);
    checks++;
    if (t_intr !== 1'b1) begin failures++; $display("FAIL cmp_intr_held: got %b expected 1", t_intr); end
    bus(1'b1, 12'h008, 32'd100, ak, rd);
    checks++;
    if (t_intr !== 1'b1) begin failures++; $display("FAIL cmp_intr_clear_lat: got %b expected 1", t_intr); end
    cyc(1);
    checks++;
    if (t_intr !== 1'b0) begin failures++; $display("FAIL cmp_intr_cleared: got %b expected 0", t_intr); end
  endtask

  task automatic test_prescaler();
    logic ak; logic [31:0] rd;
    apply_reset();
    bus(1'b1, 12'h010, 32'h301, ak, rd);
    cyc(40);
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd10) begin failures++; $display("FAIL presc_count: got %0d expected 10", rd); end
    bus(1'b1, 12'h010, 32'h0, ak, rd);
    cyc(20);
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd10) begin failures++; $display("FAIL presc_freeze: got %0d expected 10", rd); end
  endtask

  task automatic test_carry();
    logic ak; logic [31:0] rd;
    apply_reset();
    bus(1'b1, 12'h000, 32'hFFFF_FFFE, ak, rd);
    bus(1'b1, 12'h004, 32'd0, ak, rd);
    bus(1'b1, 12'h010, 32'h1, ak, rd);
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFE) begin failures++; $display("FAIL carry_lo0: got %h expected fffffffe", rd); end
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL carry_lo1: got %h expected ffffffff", rd); end
    bus(1'b0, 12'h004, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL carry_snap_hi: got %h expected 0", rd); end
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd1) begin failures++; $display("FAIL carry_lo_after: got %h expected 1", rd); end
    bus(1'b0, 12'h004, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd1) begin failures++; $display("FAIL carry_hi_after: got %h expected 1", rd); end
  endtask

  task automatic test_write_vs_tick();
    logic ak; logic [31:0] rd;
    apply_reset();
    bus(1'b1, 12'h010, 32'h1, ak, rd);
    cyc(3);
    bus(1'b1, 12'h000, 32'h20, ak, rd);
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'h20) begin failures++; $display("FAIL wvt_written: got %h expected 20", rd); end
    bus(1'b0, 12'h000, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'h21) begin failures++; $display("FAIL wvt_next_tick: got %h expected 21", rd); end
  endtask

  task automatic test_back_to_back();
    logic ak; logic [31:0] rd;
    bus(1'b0, 12'h010, 32'd0, ak, rd);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h1) begin failures++; $display("FAIL b2b_rd0: got ack=%b data=%h expected ack=1 data=1", ak, rd); end
    bus(1'b1, 12'h010, 32'h501, ak, rd);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL b2b_wr: got ack=%b data=%h expected ack=1 data=0", ak, rd); end
    bus(1'b0, 12'h010, 32'd0, ak, rd);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h501) begin failures++; $display("FAIL b2b_rd1: got ack=%b data=%h expected ack=1 data=501", ak, rd); end
    bus(1'b1, 12'h01C, 32'hFFFF_FFFF, ak, rd);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL unmapped_wr: got ack=%b data=%h expected ack=1 data=0", ak, rd); end
    bus(1'b0, 12'h01C, 32'd0, ak, rd);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL unmapped_rd: got ack=%b data=%h expected ack=1 data=0", ak, rd); end
    bus(1'b0, 12'h010, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'h501) begin failures++; $display("FAIL unmapped_ctrl_kept: got %h expected 501", rd); end
    bus(1'b0, 12'h008, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL unmapped_cmp_kept: got %h expected ffffffff", rd); end
    bus(1'b1, 12'h010, 32'hFFFF_FFFF, ak, rd);
    bus(1'b0, 12'h010, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'h0000_FF01) begin failures++; $display("FAIL ctrl_mask: got %h expected 0000ff01", rd); end
  endtask

  task automatic test_random();
    logic ak; logic [31:0] rd;
    logic [2:0] off;
    logic [31:0] d;
    apply_reset();
    bus(1'b1, 12'h010, 32'h1, ak, rd);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cyc(1);
      end else begin
        off = 3'($urandom_range(0, 7));
        d = $urandom;
        case (off)
          3'd0: d = 32'($urandom_range(0, 60));
          3'd1: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
          3'd2: d = 32'($urandom_range(0, 80));
          3'd3: d = ($urandom_range(0, 5) == 0) ? 32'd1 : 32'd0;
          3'd4: begin d[15:8] = 8'($urandom_range(0, 3)); d[0] = ($urandom_range(0, 4) != 0); end
          default: ;
        endcase
        bus(1'($urandom_range(0, 1)), {7'($urandom), off, 2'($urandom)}, d, ak, rd);
      end
      checks++;
      if (ack !== e_ack) begin failures++; $display("FAIL rand_ack[%0d]: got %b expected %b", i, ack, e_ack); end
      checks++;
      if (rdata !== e_rd) begin failures++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, rdata, e_rd); end
      checks++;
      if (t_intr !== e_intr) begin failures++; $display("FAIL rand_intr[%0d]: got %b expected %b", i, t_intr, e_intr); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic_compare();
    test_prescaler();
    test_carry();
    test_write_vs_tick();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
